// File: rtl/vscale_pc_gen.sv
// Next-PC generator, IF-stage PC register and imem request handshake for vscale.
// Optional feature: define VSCALE_PC_RVC_EN to relax target alignment to 2 bytes.
module vscale_pc_gen #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'('h200)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      PC_src_sel,
    input  logic [31:0]     inst_DX,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] PC_DX,
    input  logic [XLEN-1:0] handler_PC,
    input  logic [XLEN-1:0] epc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] PC_PIF,
    output logic [XLEN-1:0] PC_IF,
    output logic            redirect_pending,
    output logic            misaligned_target,
    output logic [XLEN-1:0] misaligned_addr
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [2:0] SEL_PLUS_FOUR = 3'd0;
    localparam logic [2:0] SEL_BRANCH    = 3'd1;
    localparam logic [2:0] SEL_JAL       = 3'd2;
    localparam logic [2:0] SEL_JALR      = 3'd3;
    localparam logic [2:0] SEL_REPLAY    = 3'd4;
    localparam logic [2:0] SEL_HANDLER   = 3'd5;
    localparam logic [2:0] SEL_EPC       = 3'd6;

    logic [1:0]        r_state;
    logic [XLEN-1:0]   r_pc_if;
    logic [XLEN-1:0]   r_pend_pc;
    logic              r_misaligned;
    logic [XLEN-1:0]   r_misaligned_addr;

    logic signed [12:0] w_imm_b_raw;
    logic signed [20:0] w_imm_j_raw;
    logic signed [11:0] w_imm_i_raw;
    logic [XLEN-1:0]   w_imm_b;
    logic [XLEN-1:0]   w_imm_j;
    logic [XLEN-1:0]   w_imm_i;
    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_raw_tgt;
    logic [XLEN-1:0]   w_tgt;
    logic              w_is_ctl;
    logic              w_misal;
    logic              w_redirect;
    logic              w_accept;
    logic              w_unused_opcode;

    assign w_imm_b_raw = {inst_DX[31], inst_DX[7], inst_DX[30:25], inst_DX[11:8], 1'b0};
    assign w_imm_j_raw = {inst_DX[31], inst_DX[19:12], inst_DX[20], inst_DX[30:21], 1'b0};
    assign w_imm_i_raw = inst_DX[31:20];
    assign w_imm_b     = XLEN'(w_imm_b_raw);
    assign w_imm_j     = XLEN'(w_imm_j_raw);
    assign w_imm_i     = XLEN'(w_imm_i_raw);
    assign w_unused_opcode = ^inst_DX[6:0];

    assign w_pc_plus4 = r_pc_if + XLEN'(4);

    always_comb begin
        w_raw_tgt = w_pc_plus4;
        case (PC_src_sel)
            SEL_BRANCH:  w_raw_tgt = PC_DX + w_imm_b;
            SEL_JAL:     w_raw_tgt = PC_DX + w_imm_j;
            SEL_JALR:    w_raw_tgt = (rs1_data + w_imm_i) & ~XLEN'(1);
            SEL_REPLAY:  w_raw_tgt = r_pc_if;
            SEL_HANDLER: w_raw_tgt = handler_PC;
            SEL_EPC:     w_raw_tgt = epc;
            default:     w_raw_tgt = w_pc_plus4;
        endcase
    end

    assign w_is_ctl = (PC_src_sel == SEL_BRANCH) || (PC_src_sel == SEL_JAL) ||
                      (PC_src_sel == SEL_JALR);

`ifdef VSCALE_PC_RVC_EN
    assign w_misal = w_is_ctl && w_raw_tgt[0];
`else
    assign w_misal = w_is_ctl && (w_raw_tgt[1:0] != 2'b00);
`endif

    // A rejected control transfer falls back to sequential fetch.
    assign w_tgt      = w_misal ? w_pc_plus4 : w_raw_tgt;
    assign w_redirect = !w_misal && (w_is_ctl || (PC_src_sel == SEL_HANDLER) ||
                                     (PC_src_sel == SEL_EPC));

    always_comb begin
        PC_PIF         = RESET_VECTOR;
        imem_req_valid = 1'b0;
        case (r_state)
            ST_RUN: begin
                PC_PIF         = w_tgt;
                imem_req_valid = 1'b1;
            end
            ST_HOLD: begin
                PC_PIF         = w_redirect ? w_tgt : r_pend_pc;
                imem_req_valid = 1'b1;
            end
            default: begin
                PC_PIF         = RESET_VECTOR;
                imem_req_valid = 1'b0;
            end
        endcase
    end

    assign w_accept = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= ST_BOOT;
            r_pc_if           <= RESET_VECTOR - XLEN'(4);
            r_pend_pc         <= '0;
            r_misaligned      <= 1'b0;
            r_misaligned_addr <= '0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_accept) begin
                        r_pc_if <= PC_PIF;
                    end else if (w_redirect) begin
                        r_pend_pc <= w_tgt;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_accept) begin
                        r_pc_if <= PC_PIF;
                        r_state <= ST_RUN;
                    end else if (w_redirect) begin
                        r_pend_pc <= w_tgt;
                    end
                end
                default: r_state <= ST_BOOT;
            endcase

            // Select is ignored in BOOT, so no misalignment is reported there.
            r_misaligned <= w_misal && (r_state != ST_BOOT);
            if (w_misal && (r_state != ST_BOOT))
                r_misaligned_addr <= w_raw_tgt;
        end
    end

    assign PC_IF             = r_pc_if;
    assign redirect_pending  = (r_state == ST_HOLD);
    assign misaligned_target = r_misaligned;
    assign misaligned_addr   = r_misaligned_addr;

endmodule

// File: tb/tb_vscale_pc_gen.sv
// Directed self-checking bench for vscale_pc_gen (default XLEN=32, RESET_VECTOR=0x200).
module tb_vscale_pc_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  PC_src_sel;
    logic [31:0] inst_DX;
    logic [31:0] rs1_data;
    logic [31:0] PC_DX;
    logic [31:0] handler_PC;
    logic [31:0] epc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] PC_PIF;
    logic [31:0] PC_IF;
    logic        redirect_pending;
    logic        misaligned_target;
    logic [31:0] misaligned_addr;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] base_pc;

    vscale_pc_gen #(.XLEN(32), .RESET_VECTOR(32'h200)) dut (
        .clk(clk), .reset_n(reset_n), .PC_src_sel(PC_src_sel), .inst_DX(inst_DX),
        .rs1_data(rs1_data), .PC_DX(PC_DX), .handler_PC(handler_PC), .epc(epc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .PC_PIF(PC_PIF), .PC_IF(PC_IF), .redirect_pending(redirect_pending),
        .misaligned_target(misaligned_target), .misaligned_addr(misaligned_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input int imm);
        logic [31:0] v;
        logic [31:0] r;
        v = imm;
        r = '0;
        r[31] = v[12]; r[7] = v[11]; r[30:25] = v[10:5]; r[11:8] = v[4:1];
        return r;
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [31:0] v;
        logic [31:0] r;
        v = imm;
        r = '0;
        r[31] = v[20]; r[19:12] = v[19:12]; r[20] = v[11]; r[30:21] = v[10:1];
        return r;
    endfunction

    function automatic logic [31:0] enc_i(input int imm);
        logic [31:0] v;
        logic [31:0] r;
        v = imm;
        r = '0;
        r[31:20] = v[11:0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; imem_req_ready = 1'b1; PC_src_sel = 3'd0;
        inst_DX = '0; rs1_data = '0; PC_DX = '0; handler_PC = '0; epc = '0;
        step(); step();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (PC_PIF !== 32'h200) begin n_err++; $display("FAIL reset_pif: got %h want 00000200", PC_PIF); end
        n_cmp++; if (PC_IF !== 32'h1FC) begin n_err++; $display("FAIL reset_pc_if: got %h want 000001fc", PC_IF); end
        n_cmp++; if (redirect_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0", redirect_pending); end
        n_cmp++; if (misaligned_target !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b want 0", misaligned_target); end
        n_cmp++; if (misaligned_addr !== 32'h0) begin n_err++; $display("FAIL reset_mis_addr: got %h want 0", misaligned_addr); end
    endtask

    task automatic test_boot();
        reset_n = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid: got %b want 0", imem_req_valid); end
        step();
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL run_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (PC_PIF !== 32'h200) begin n_err++; $display("FAIL boot_fetch0: got %h want 00000200", PC_PIF); end
        step();
        n_cmp++; if (PC_IF !== 32'h200) begin n_err++; $display("FAIL boot_pc_if0: got %h want 00000200", PC_IF); end
        n_cmp++; if (PC_PIF !== 32'h204) begin n_err++; $display("FAIL boot_fetch1: got %h want 00000204", PC_PIF); end
        step();
        n_cmp++; if (PC_IF !== 32'h204) begin n_err++; $display("FAIL boot_pc_if1: got %h want 00000204", PC_IF); end
        n_cmp++; if (PC_PIF !== 32'h208) begin n_err++; $display("FAIL boot_fetch2: got %h want 00000208", PC_PIF); end
        step();
        n_cmp++; if (PC_IF !== 32'h208) begin n_err++; $display("FAIL boot_pc_if2: got %h want 00000208", PC_IF); end
    endtask

    task automatic test_branch();
        PC_DX = 32'h1000; inst_DX = enc_b(-8); PC_src_sel = 3'd1; imem_req_ready = 1'b1;
        #1;
        n_cmp++; if (PC_PIF !== 32'hFF8) begin n_err++; $display("FAIL branch_pif: got %h want 00000ff8", PC_PIF); end
        step();
        PC_src_sel = 3'd0;
        n_cmp++; if (PC_IF !== 32'hFF8) begin n_err++; $display("FAIL branch_pc_if: got %h want 00000ff8", PC_IF); end
        n_cmp++; if (misaligned_target !== 1'b0) begin n_err++; $display("FAIL branch_mis: got %b want 0", misaligned_target); end
    endtask

    task automatic test_held_redirect();
        PC_DX = 32'h2000; inst_DX = enc_j(32'h400); PC_src_sel = 3'd2; imem_req_ready = 1'b0;
        #1;
        n_cmp++; if (PC_PIF !== 32'h2400) begin n_err++; $display("FAIL hold_issue_pif: got %h want 00002400", PC_PIF); end
        step();
        PC_src_sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (redirect_pending !== 1'b1) begin n_err++; $display("FAIL hold_pending[%0d]: got %b want 1", i, redirect_pending); end
            n_cmp++; if (PC_PIF !== 32'h2400) begin n_err++; $display("FAIL hold_pif[%0d]: got %h want 00002400", i, PC_PIF); end
            n_cmp++; if (PC_IF !== 32'hFF8) begin n_err++; $display("FAIL hold_pc_if[%0d]: got %h want 00000ff8", i, PC_IF); end
            step();
        end
        imem_req_ready = 1'b1;
        #1;
        n_cmp++; if (PC_PIF !== 32'h2400) begin n_err++; $display("FAIL hold_accept_pif: got %h want 00002400", PC_PIF); end
        step();
        n_cmp++; if (PC_IF !== 32'h2400) begin n_err++; $display("FAIL hold_pc_if: got %h want 00002400", PC_IF); end
        n_cmp++; if (redirect_pending !== 1'b0) begin n_err++; $display("FAIL hold_exit: got %b want 0", redirect_pending); end
        n_cmp++; if (PC_PIF !== 32'h2404) begin n_err++; $display("FAIL hold_next_pif: got %h want 00002404", PC_PIF); end
    endtask

    task automatic test_overwrite();
        PC_DX = 32'h2000; inst_DX = enc_j(32'h400); PC_src_sel = 3'd2; imem_req_ready = 1'b0;
        step();
        PC_src_sel = 3'd5; handler_PC = 32'h100;
        #1;
        n_cmp++; if (PC_PIF !== 32'h100) begin n_err++; $display("FAIL ovw_pif0: got %h want 00000100", PC_PIF); end
        step();
        PC_src_sel = 3'd0; imem_req_ready = 1'b1;
        #1;
        n_cmp++; if (PC_PIF !== 32'h100) begin n_err++; $display("FAIL ovw_pif1: got %h want 00000100", PC_PIF); end
        step();
        n_cmp++; if (PC_IF !== 32'h100) begin n_err++; $display("FAIL ovw_pc_if: got %h want 00000100", PC_IF); end
        n_cmp++; if (PC_PIF !== 32'h104) begin n_err++; $display("FAIL ovw_next_pif: got %h want 00000104", PC_PIF); end
    endtask

    task automatic test_sources();
        PC_src_sel = 3'd4;
        #1;
        n_cmp++; if (PC_PIF !== 32'h100) begin n_err++; $display("FAIL replay_pif: got %h want 00000100", PC_PIF); end
        epc = 32'h3330; PC_src_sel = 3'd6;
        #1;
        n_cmp++; if (PC_PIF !== 32'h3330) begin n_err++; $display("FAIL epc_pif: got %h want 00003330", PC_PIF); end
        PC_src_sel = 3'd7;
        #1;
        n_cmp++; if (PC_PIF !== 32'h104) begin n_err++; $display("FAIL rsvd_pif: got %h want 00000104", PC_PIF); end
        PC_src_sel = 3'd0;
    endtask

    task automatic test_misaligned();
        rs1_data = 32'h1002; inst_DX = enc_i(0); PC_src_sel = 3'd3; imem_req_ready = 1'b1;
        #1;
`ifdef VSCALE_PC_RVC_EN
        n_cmp++; if (PC_PIF !== 32'h1002) begin n_err++; $display("FAIL jalr_pif: got %h want 00001002", PC_PIF); end
        step();
        PC_src_sel = 3'd0;
        n_cmp++; if (misaligned_target !== 1'b0) begin n_err++; $display("FAIL jalr_pulse: got %b want 0", misaligned_target); end
        n_cmp++; if (PC_IF !== 32'h1002) begin n_err++; $display("FAIL jalr_pc_if: got %h want 00001002", PC_IF); end
        base_pc = 32'h1006;
`else
        n_cmp++; if (PC_PIF !== 32'h104) begin n_err++; $display("FAIL jalr_pif: got %h want 00000104", PC_PIF); end
        step();
        PC_src_sel = 3'd0;
        n_cmp++; if (misaligned_target !== 1'b1) begin n_err++; $display("FAIL jalr_pulse: got %b want 1", misaligned_target); end
        n_cmp++; if (misaligned_addr !== 32'h1002) begin n_err++; $display("FAIL jalr_addr: got %h want 00001002", misaligned_addr); end
        n_cmp++; if (PC_IF !== 32'h104) begin n_err++; $display("FAIL jalr_pc_if: got %h want 00000104", PC_IF); end
        base_pc = 32'h108;
`endif
        step();
        n_cmp++; if (misaligned_target !== 1'b0) begin n_err++; $display("FAIL mis_pulse_end: got %b want 0", misaligned_target); end
        n_cmp++; if (PC_IF !== base_pc) begin n_err++; $display("FAIL mis_pc_if: got %h want %h", PC_IF, base_pc); end
    endtask

    task automatic test_back_to_back();
        PC_DX = 32'h3001; inst_DX = enc_j(8); PC_src_sel = 3'd2;
        #1;
        n_cmp++; if (PC_PIF !== base_pc + 32'd4) begin n_err++; $display("FAIL b2b_pif0: got %h want %h", PC_PIF, base_pc + 32'd4); end
        step();
        inst_DX = enc_b(16); PC_src_sel = 3'd1;
        n_cmp++; if (misaligned_target !== 1'b1) begin n_err++; $display("FAIL b2b_pulse0: got %b want 1", misaligned_target); end
        n_cmp++; if (misaligned_addr !== 32'h3009) begin n_err++; $display("FAIL b2b_addr0: got %h want 00003009", misaligned_addr); end
        #1;
        n_cmp++; if (PC_PIF !== base_pc + 32'd8) begin n_err++; $display("FAIL b2b_pif1: got %h want %h", PC_PIF, base_pc + 32'd8); end
        step();
        PC_src_sel = 3'd0;
        n_cmp++; if (misaligned_target !== 1'b1) begin n_err++; $display("FAIL b2b_pulse1: got %b want 1", misaligned_target); end
        n_cmp++; if (misaligned_addr !== 32'h3011) begin n_err++; $display("FAIL b2b_addr1: got %h want 00003011", misaligned_addr); end
        step();
        n_cmp++; if (misaligned_target !== 1'b0) begin n_err++; $display("FAIL b2b_pulse_end: got %b want 0", misaligned_target); end
        n_cmp++; if (misaligned_addr !== 32'h3011) begin n_err++; $display("FAIL b2b_addr_hold: got %h want 00003011", misaligned_addr); end
    endtask

    task automatic test_wrap();
        rs1_data = 32'hFFFF_FFFC; inst_DX = enc_i(0); PC_src_sel = 3'd3; imem_req_ready = 1'b1;
        step();
        PC_src_sel = 3'd0;
        n_cmp++; if (PC_IF !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc_if: got %h want fffffffc", PC_IF); end
        #1;
        n_cmp++; if (PC_PIF !== 32'h0) begin n_err++; $display("FAIL wrap_pif: got %h want 00000000", PC_PIF); end
        step();
        n_cmp++; if (PC_IF !== 32'h0) begin n_err++; $display("FAIL wrap_pc_if_next: got %h want 00000000", PC_IF); end
    endtask

    task automatic test_reset_mid_hold();
        PC_DX = 32'h2000; inst_DX = enc_j(32'h400); PC_src_sel = 3'd2; imem_req_ready = 1'b0;
        step();
        PC_src_sel = 3'd0;
        n_cmp++; if (redirect_pending !== 1'b1) begin n_err++; $display("FAIL rst_hold_entry: got %b want 1", redirect_pending); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (redirect_pending !== 1'b0) begin n_err++; $display("FAIL rst_async_pending: got %b want 0", redirect_pending); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (PC_IF !== 32'h1FC) begin n_err++; $display("FAIL rst_async_pc_if: got %h want 000001fc", PC_IF); end
        step();
        reset_n = 1'b1; imem_req_ready = 1'b1;
        step();
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rst_refetch_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (PC_PIF !== 32'h200) begin n_err++; $display("FAIL rst_refetch_pif: got %h want 00000200", PC_PIF); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_branch();
        test_held_redirect();
        test_overwrite();
        test_sources();
        test_misaligned();
        test_back_to_back();
        test_wrap();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
